lcd_bus_receiver: RTL and testbench
===================================

# lcd_bus_receiver

Receiving end of the 4-bit HD44780-style character-LCD bus that `LCD_module` drives. The block samples `LCD_E`/`LCD_RS`/`LCD_RW`/`LCD_D` and reassembles nibbles into bytes. It executes the display command subset and rebuilds the two 16-character rows into `row_A`/`row_B`, using the same packing the lab tops use. It sits in self-check benches and on-board loopback tops, so LCD output can be checked without a physical panel.

## Interface
- `CLK_HZ`, default 100000000: board clock; documentation only, used by no logic.
- `clk` input, 1 bit: system clock, all logic on rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `LCD_E` input, 1 bit: enable strobe. Asynchronous to `clk`; data latches on the falling edge.
- `LCD_RS` input, 1 bit: 0 = command, 1 = data.
- `LCD_RW` input, 1 bit: 0 = write, 1 = read.
- `LCD_D` input, 4 bits: data nibble.
- `row_A` output, 128 bits: top row; bits [127:120] = column 0 ASCII.
- `row_B` output, 128 bits: bottom row, same packing.
- `byte_valid` output, 1 bit: one-cycle pulse per executed byte.
- `byte_out` output, 8 bits: last executed byte.
- `byte_rs` output, 1 bit: RS of last executed byte.
- `mode_4bit` output, 1 bit: 1 once the 4-bit interface is active.
- `display_on` output, 1 bit: D bit of the last display-control command.

## Operation
- **Input synchronizers**
  - All bus inputs pass through 2-flop synchronizers.
  - A third `E` flop provides falling-edge detect.
  - `RS`/`RW`/`D` are captured from the synchronized stage on every cycle that synchronized `E` is 1.
  - A strobe uses the last captured values.
- **Strobe filtering:** strobes with `RW`=1 are ignored and do not advance the nibble phase.
- **FSM `ST_INIT8`** (reset state)
  - Each strobe is an 8-bit-mode command `{D,4'h0}`.
  - `0x3` nibble: stay in `ST_INIT8`.
  - `0x2` nibble: `mode_4bit`<=1, go to `ST_HI`.
  - Other nibbles: stay; nothing is executed.
- **FSM `ST_HI`:** latch high nibble, go to `ST_LO`.
- **FSM `ST_LO`:** form `{hi,D}`, execute it, pulse `byte_valid`, go to `ST_HI`.
- **Command decode** (`RS`=0, priority from MSB)
  - `1xxxxxxx`: AC <= bits[6:0]; cg_sel <= 0.
  - `01xxxxxx`: cg_sel <= 1. Subsequent data bytes are discarded until the next DDRAM set.
  - `001DLxxxx`: if DL=1, `mode_4bit`<=0 and go to `ST_INIT8`.
  - `0001xxxx`: shift command, ignored.
  - `00001Dxx`: `display_on`<=D.
  - `000001Ix`: inc <= I.
  - `0000001x`: AC <= 0.
  - `00000001`: all 32 cells <= 0x20, AC <= 0, inc <= 1. Completes in the execute cycle.
  - `0x00`: no operation.
- **Data write** (`RS`=1, cg_sel=0)
  - AC `0x00`–`0x0F`: write `row_A` column AC.
  - AC `0x40`–`0x4F`: write `row_B` column AC−0x40.
  - Other AC values: the write is discarded.
  - AC always advances after a data write.
- **AC stepping** (7-bit, two-line map)
  - Increment: `0x27`→`0x40`, `0x67`→`0x00`; otherwise +1.
  - Decrement: `0x40`→`0x27`, `0x00`→`0x67`; otherwise −1.
  - AC values outside the two ranges step ±1 modulo 128.
- **Discarded writes:** CGRAM-mode data bytes still pulse `byte_valid`.

## Timing
- **Reset values:** `row_A`=`row_B`= sixteen 0x20; `byte_valid`=0; `byte_out`=0x00; `byte_rs`=0; `mode_4bit`=0; `display_on`=0. Internally AC=0, inc=1, cg_sel=0, FSM=`ST_INIT8`.
- **Latency:** `byte_valid`, `byte_out`, and row updates appear on the 3rd rising `clk` edge after the edge that first samples `LCD_E` low.
- **Bus requirements:**
  - `E` high ≥3 `clk` cycles.
  - `E` low ≥3 `clk` cycles.
  - `RS`/`RW`/`D` stable from ≥3 cycles before `E` falls until ≥1 cycle after it falls.
  - The `LCD_module` timing at 100 MHz exceeds these minimums.
- **Busy flag:** the block has no busy flag; the execute time of every command is one cycle.
- **Reset mid-transfer:** `reset_n` low is immediate. A half-received byte is dropped and the FSM returns to `ST_INIT8`.
- **Input glitches:** an `E` pulse shorter than the synchronizer can sample is not detected; no strobe results.

## Configuration
- **`LCD_RX_BLANK_OFF_EN` defined**
  - While `display_on`=0, `row_A` and `row_B` read as all 0x20.
  - The buffer is retained and writes still land.
  - `display_on`=1 exposes the buffer again.
- **`LCD_RX_BLANK_OFF_EN` undefined:** rows always show the buffer; `display_on` is status only.

## Test plan
- **4-bit entry:** strobe nibbles 3,3,3,2 with RS=0, RW=0 → `mode_4bit`=1 after the 4th strobe. No `byte_valid` during the sequence.
- **Command and text write:** bytes 0x28, 0x06, 0x0C, 0x01, 0x80, then "Prime #" as data → `display_on`=1. `row_A[127:72]`="Prime #", remainder 0x20. `byte_valid` pulses 12 times.
- **Bottom row and overflow:** 0xC0, then 17 data bytes "show a message..!" → `row_B`="show a message..". The 17th byte lands at AC `0x50`, which is invisible, and the rows are unchanged.
- **Address wrap and decrement:**
  - 0xA7 then 'X','Y' → 'Y' at `row_B` column 0.
  - Then 0x04, 0x80, 'Z','W' → 'Z' at `row_A` column 0. AC becomes `0x67`; 'W' is discarded.
- **Reset mid-byte:** send high nibble 0x4, pulse `reset_n` low for 2 cycles. Rows return to spaces and `mode_4bit`=0. After re-init, 0x80 then 0x41 → 'A' at `row_A` column 0.
- **Blank-off macro:** with `LCD_RX_BLANK_OFF_EN` defined, send 0x08 → rows all 0x20. Send 0x0C → prior text reappears. Undefined build: text is never blanked.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// Receiver for the 4-bit HD44780-style character-LCD bus: rebuilds bytes and mirrors the two 16-column rows.
// Optional build macro LCD_RX_BLANK_OFF_EN: rows read as spaces while the display is switched off.
module lcd_bus_receiver #(
  parameter int CLK_HZ = 100000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic         mode_4bit,
  output logic         display_on
);

  if (CLK_HZ <= 0) begin : g_bad_clk_hz
    $error("CLK_HZ must be positive");
  end

  typedef enum logic [1:0] {
    ST_INIT8 = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2
  } state_t;

  localparam logic [127:0] BLANK_ROW = {16{8'h20}};

  // Two-line address map: 0x00-0x27 and 0x40-0x67 chain into each other.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      case (a)
        7'h27:   r = 7'h40;
        7'h67:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h40:   r = 7'h27;
        7'h00:   r = 7'h67;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  logic       e_s1, e_s2, e_s3, strobe_r;
  logic       rs_s1, rs_s2, rw_s1, rw_s2;
  logic [3:0] d_s1, d_s2;
  logic       cap_rs, cap_rw;
  logic [3:0] cap_d;

  // NOTE: every clocked register uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_s1 <= 1'b0; e_s2 <= 1'b0; e_s3 <= 1'b0; strobe_r <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0; rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      d_s1 <= 4'h0; d_s2 <= 4'h0;
      cap_rs <= 1'b0; cap_rw <= 1'b0; cap_d <= 4'h0;
    end else begin
      e_s1  <= LCD_E;   e_s2  <= e_s1;
      e_s3  <= e_s2;
      rs_s1 <= LCD_RS;  rs_s2 <= rs_s1;
      rw_s1 <= LCD_RW;  rw_s2 <= rw_s1;
      d_s1  <= LCD_D;   d_s2  <= d_s1;
      strobe_r <= e_s3 & ~e_s2;
      if (e_s2) begin
        cap_rs <= rs_s2;
        cap_rw <= rw_s2;
        cap_d  <= d_s2;
      end
    end
  end

  state_t     st, st_next;
  logic [3:0] hi;
  logic       strobe_ok;
  logic       exec;
  logic [7:0] exec_byte;

  assign strobe_ok = strobe_r & ~cap_rw;
  assign exec_byte = {hi, cap_d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= ST_INIT8;
    else          st <= st_next;
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    st_next = st;
    exec    = 1'b0;
    case (st)
      ST_INIT8: if (strobe_ok && cap_d == 4'h2) st_next = ST_HI;
      ST_HI:    if (strobe_ok) st_next = ST_LO;
      ST_LO: begin
        if (strobe_ok) begin
          exec    = 1'b1;
          st_next = ST_HI;
          if (!cap_rs && exec_byte[7:5] == 3'b001 && exec_byte[4]) st_next = ST_INIT8;
        end
      end
      default: st_next = ST_INIT8;
    endcase
  end

  logic [127:0] row_a_buf, row_b_buf;
  logic [6:0]   ac;
  logic         inc, cg_sel;

  // NOTE: the display buffer is plain registers, so it takes a reset value like any other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi         <= 4'h0;
      row_a_buf  <= BLANK_ROW;
      row_b_buf  <= BLANK_ROW;
      ac         <= 7'h00;
      inc        <= 1'b1;
      cg_sel     <= 1'b0;
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      byte_rs    <= 1'b0;
      mode_4bit  <= 1'b0;
      display_on <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (st == ST_INIT8 && strobe_ok && cap_d == 4'h2) mode_4bit <= 1'b1;
      if (st == ST_HI && strobe_ok) hi <= cap_d;
      if (exec) begin
        byte_valid <= 1'b1;
        byte_out   <= exec_byte;
        byte_rs    <= cap_rs;
        if (!cap_rs) begin
          if (exec_byte[7]) begin
            ac     <= exec_byte[6:0];
            cg_sel <= 1'b0;
          end else if (exec_byte[6]) begin
            cg_sel <= 1'b1;
          end else if (exec_byte[5]) begin
            if (exec_byte[4]) mode_4bit <= 1'b0;
          end else if (exec_byte[4]) begin
            // cursor/display shift: no visible effect on the mirrored rows
          end else if (exec_byte[3]) begin
            display_on <= exec_byte[2];
          end else if (exec_byte[2]) begin
            inc <= exec_byte[1];
          end else if (exec_byte[1]) begin
            ac <= 7'h00;
          end else if (exec_byte[0]) begin
            row_a_buf <= BLANK_ROW;
            row_b_buf <= BLANK_ROW;
            ac        <= 7'h00;
            inc       <= 1'b1;
          end
        end else if (!cg_sel) begin
          if (ac[6:4] == 3'b000) row_a_buf[{~ac[3:0], 3'b000} +: 8] <= exec_byte;
          if (ac[6:4] == 3'b100) row_b_buf[{~ac[3:0], 3'b000} +: 8] <= exec_byte;
          ac <= ac_step(ac, inc);
        end
      end
    end
  end

`ifdef LCD_RX_BLANK_OFF_EN
  assign row_A = display_on ? row_a_buf : BLANK_ROW;
  assign row_B = display_on ? row_b_buf : BLANK_ROW;
`else
  assign row_A = row_a_buf;
  assign row_B = row_b_buf;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives bus nibbles and compares rows/status against hand-built values.
module tb_lcd_bus_receiver;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [3:0]   LCD_D = 4'h0;
  logic [127:0] row_A, row_B;
  logic         byte_valid, byte_rs, mode_4bit, display_on;
  logic [7:0]   byte_out;

  int total = 0;
  int bad = 0;
  int bv_count = 0;

  localparam logic [127:0] SPACES = {16{8'h20}};

  lcd_bus_receiver #(.CLK_HZ(100000000)) dut (
    .clk(clk), .reset_n(reset_n),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_D(LCD_D),
    .row_A(row_A), .row_B(row_B),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs),
    .mode_4bit(mode_4bit), .display_on(display_on)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (byte_valid === 1'b1) bv_count++;

  task automatic send_nibble(input logic rs, input logic rw, input logic [3:0] d, input bit chk_lat);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = rw; LCD_D = d;
    repeat (4) @(negedge clk);
    LCD_E = 1'b1;
    repeat (4) @(negedge clk);
    LCD_E = 1'b0;
    if (chk_lat) begin
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (byte_valid !== 1'b0) begin
        bad++;
        $display("FAIL latency_early: byte_valid=%b after 3 edges, want 0", byte_valid);
      end
      @(posedge clk);
      #1;
      total++;
      if (byte_valid !== 1'b1) begin
        bad++;
        $display("FAIL latency_edge: byte_valid=%b on 4th edge, want 1", byte_valid);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nibble(rs, 1'b0, b[7:4], 1'b0);
    send_nibble(rs, 1'b0, b[3:0], 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i]);
  endtask

  task automatic do_init();
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h2, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (row_A !== SPACES) begin bad++; $display("FAIL reset_row_A: got %h want %h", row_A, SPACES); end
    total++; if (row_B !== SPACES) begin bad++; $display("FAIL reset_row_B: got %h want %h", row_B, SPACES); end
    total++; if ({byte_valid, byte_out, byte_rs, mode_4bit, display_on} !== 12'h000) begin
      bad++; $display("FAIL reset_status: bv=%b out=%h rs=%b m4=%b on=%b, want all 0",
                      byte_valid, byte_out, byte_rs, mode_4bit, display_on);
    end
  endtask

  task automatic test_init();
    bv_count = 0;
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    total++; if (mode_4bit !== 1'b0) begin bad++; $display("FAIL init_early_mode: got %b want 0", mode_4bit); end
    send_nibble(1'b0, 1'b0, 4'h2, 1'b0);
    total++; if (mode_4bit !== 1'b1) begin bad++; $display("FAIL init_mode: got %b want 1", mode_4bit); end
    total++; if (bv_count !== 0) begin bad++; $display("FAIL init_no_valid: got %0d pulses want 0", bv_count); end
  endtask

  task automatic test_cmd_text();
    bv_count = 0;
    send_nibble(1'b0, 1'b0, 4'h2, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h8, 1'b1);
    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'h0C);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h80);
    send_str("Prime #");
    total++; if (display_on !== 1'b1) begin bad++; $display("FAIL text_display_on: got %b want 1", display_on); end
    total++; if (row_A !== {"Prime #", {9{8'h20}}}) begin
      bad++; $display("FAIL text_row_A: got %h want %h", row_A, {"Prime #", {9{8'h20}}});
    end
    total++; if (row_B !== SPACES) begin bad++; $display("FAIL text_row_B: got %h want %h", row_B, SPACES); end
    total++; if (bv_count !== 12) begin bad++; $display("FAIL text_valid_count: got %0d want 12", bv_count); end
    total++; if (byte_out !== 8'h23 || byte_rs !== 1'b1) begin
      bad++; $display("FAIL text_last_byte: got %h/%b want 23/1", byte_out, byte_rs);
    end
  endtask

  task automatic test_read_ignored();
    send_nibble(1'b0, 1'b1, 4'hF, 1'b0);
    send_byte(1'b1, "Q");
    total++; if (row_A !== {"Prime #Q", {8{8'h20}}}) begin
      bad++; $display("FAIL read_strobe_row_A: got %h want %h", row_A, {"Prime #Q", {8{8'h20}}});
    end
  endtask

  task automatic test_bottom_row();
    send_byte(1'b0, 8'hC0);
    send_str("show a message..!");
    total++; if (row_B !== "show a message..") begin
      bad++; $display("FAIL bottom_row_B: got %h want %h", row_B, 128'("show a message.."));
    end
    total++; if (row_A !== {"Prime #Q", {8{8'h20}}}) begin
      bad++; $display("FAIL bottom_row_A: got %h want %h", row_A, {"Prime #Q", {8{8'h20}}});
    end
  endtask

  task automatic test_wrap();
    send_byte(1'b0, 8'hA7);
    send_str("XY");
    total++; if (row_B !== "Yhow a message..") begin
      bad++; $display("FAIL wrap_inc_row_B: got %h want %h", row_B, 128'("Yhow a message.."));
    end
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h80);
    send_str("ZW");
    total++; if (row_A !== {"Zrime #Q", {8{8'h20}}}) begin
      bad++; $display("FAIL wrap_dec_row_A: got %h want %h", row_A, {"Zrime #Q", {8{8'h20}}});
    end
    total++; if (row_B !== "Yhow a message..") begin
      bad++; $display("FAIL wrap_dec_row_B: got %h want %h", row_B, 128'("Yhow a message.."));
    end
    send_byte(1'b0, 8'h06);
  endtask

  task automatic test_cgram();
    bv_count = 0;
    send_byte(1'b0, 8'h40);
    send_byte(1'b1, "K");
    total++; if (bv_count !== 2) begin bad++; $display("FAIL cgram_valid_count: got %0d want 2", bv_count); end
    total++; if (byte_out !== 8'h4B) begin bad++; $display("FAIL cgram_byte_out: got %h want 4b", byte_out); end
    total++; if (row_A !== {"Zrime #Q", {8{8'h20}}} || row_B !== "Yhow a message..") begin
      bad++; $display("FAIL cgram_rows: got %h / %h, want unchanged", row_A, row_B);
    end
  endtask

  task automatic test_blank();
    send_byte(1'b0, 8'h08);
    total++; if (display_on !== 1'b0) begin bad++; $display("FAIL blank_display_on: got %b want 0", display_on); end
`ifdef LCD_RX_BLANK_OFF_EN
    total++; if (row_A !== SPACES || row_B !== SPACES) begin
      bad++; $display("FAIL blank_rows_off: got %h / %h want spaces", row_A, row_B);
    end
`else
    total++; if (row_A !== {"Zrime #Q", {8{8'h20}}} || row_B !== "Yhow a message..") begin
      bad++; $display("FAIL blank_rows_kept: got %h / %h want text", row_A, row_B);
    end
`endif
    send_byte(1'b0, 8'h0C);
    total++; if (row_A !== {"Zrime #Q", {8{8'h20}}} || row_B !== "Yhow a message..") begin
      bad++; $display("FAIL blank_rows_on: got %h / %h want text", row_A, row_B);
    end
  endtask

  task automatic test_dl8();
    send_byte(1'b0, 8'h30);
    total++; if (mode_4bit !== 1'b0) begin bad++; $display("FAIL dl8_mode: got %b want 0", mode_4bit); end
    bv_count = 0;
    send_nibble(1'b0, 1'b0, 4'h4, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h1, 1'b0);
    total++; if (bv_count !== 0) begin bad++; $display("FAIL dl8_no_exec: got %0d pulses want 0", bv_count); end
  endtask

  task automatic test_reset_mid();
    do_init();
    send_nibble(1'b0, 1'b0, 4'h4, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (row_A !== SPACES || row_B !== SPACES) begin
      bad++; $display("FAIL midrst_rows: got %h / %h want spaces", row_A, row_B);
    end
    total++; if (mode_4bit !== 1'b0) begin bad++; $display("FAIL midrst_mode: got %b want 0", mode_4bit); end
    do_init();
    send_byte(1'b0, 8'h80);
    send_byte(1'b1, 8'h41);
    total++; if (row_A !== {"A", {15{8'h20}}}) begin
      bad++; $display("FAIL midrst_row_A: got %h want %h", row_A, {"A", {15{8'h20}}});
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_cmd_text();
    test_read_ignored();
    test_bottom_row();
    test_wrap();
    test_cgram();
    test_blank();
    test_dl8();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
